// File: rtl/status_register_unit.sv
// NZCV status register with same-cycle EXE bypass and an ID->EXE flag-setter
// tracker that stalls conditional instructions until their flags are produced.
module status_register_unit #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             exe_valid,
  input  logic             exe_s,
  input  logic [3:0]       alu_status,
  input  logic             id_valid,
  input  logic             id_s,
  input  logic [3:0]       id_cond,
  output logic [3:0]       status_bits,
  output logic [3:0]       sreg_q,
  output logic             flag_hazard,
  output logic [CNT_W-1:0] pending_count
);

  logic             wr_en;
  logic             dep;
  logic             issue;
  logic [DEPTH-1:0] track;
  logic [CNT_W-1:0] cnt;

  // flush never gates the write: the EXE instruction is older than the branch
  assign wr_en       = exe_valid & exe_s & ~freeze;
  assign status_bits = wr_en ? alu_status : sreg_q;
  assign dep         = id_valid & (id_cond != 4'b1110) & (id_cond != 4'b1111);
  assign issue       = id_valid & id_s & ~flag_hazard;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       sreg_q <= '0;
    else if (wr_en) sreg_q <= alu_status;
  end

  generate
    if (DEPTH == 1) begin : g_d1
      // the only slot is EXE, which the bypass already covers
      assign flag_hazard = 1'b0;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)         track    <= '0;
        else if (!freeze) track[0] <= flush ? 1'b0 : issue;
      end
    end else begin : g_dn
      assign flag_hazard = dep & (|track[DEPTH-2:0]);
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) track <= '0;
        else if (!freeze) begin
          if (flush) track <= '0;
          else       track <= {track[DEPTH-2:0], issue};
        end
      end
    end
  endgenerate

  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++)
      cnt = cnt + {{(CNT_W-1){1'b0}}, track[i]};
  end
  assign pending_count = cnt;

endmodule
